pixel_frame_buffer: RTL and testbench
=====================================

// Module: pixel_frame_buffer
// PURPOSE
//   Receiving end of the binarised pixel stream (valid + pixel + index) from the camera front end.
//   Captures one complete 28x28 frame into an internal 1-bit-per-pixel store.
//   Replays the stored frame in index order to the classifier over a valid/ready stream.
//   Decouples camera timing from classifier timing; one frame is held at a time.
// PARAMETERS
//   WEIGHTS_ADDR  10   width of pixel index (write and read side)
//   GRAY_WIDTH    8    width of pixel data bus (value is 0 or 1)
//   NUM_PIXELS    784  pixels per frame; must be <= 2**WEIGHTS_ADDR
// PORTS
//   pclk          in   1             single clock; all logic on posedge
//   rst           in   1             asynchronous, active-high reset
//   pix_valid     in   1             write strobe, one pixel per cycle when high
//   pix_data      in   GRAY_WIDTH    binarised pixel; stored bit = (pix_data != 0)
//   pix_index     in   WEIGHTS_ADDR  raster index of pix_data, 0..NUM_PIXELS-1
//   rd_start      in   1             classifier request to replay stored frame
//   rd_ready      in   1             classifier accepts current read beat
//   frame_ready   out  1             complete frame held, replay not yet started
//   rd_valid      out  1             read beat valid
//   rd_data       out  GRAY_WIDTH    stored pixel, zero-extended (0 or 1)
//   rd_index      out  WEIGHTS_ADDR  index of rd_data
//   rd_last       out  1             high with the beat for index NUM_PIXELS-1
//   frame_done    out  1             1-cycle pulse after last beat accepted
//   seq_err       out  1             1-cycle pulse: capture aborted on index error
//   frame_drop    out  1             1-cycle pulse: index-0 write arrived while busy
// BEHAVIOUR
//   Reset: state IDLE, wr_ptr=0, rd_ptr=0; every output 0. Store not cleared, never read before a new capture.
//   Reset mid-capture or mid-replay: immediate abort to IDLE; partial frame discarded.
//   States: IDLE, CAPTURE, READY, READOUT.
//   IDLE: pix_valid with pix_index==0 writes store[0], wr_ptr<=1, go CAPTURE. Any other index ignored, no error.
//   CAPTURE: pix_valid with pix_index==wr_ptr writes store[wr_ptr], wr_ptr++.
//     - Write of index NUM_PIXELS-1 -> READY; frame_ready=1 from next cycle.
//     - pix_index==0 -> restart: store[0] written, wr_ptr<=1, no error pulse.
//     - Any other mismatch (incl. index >= NUM_PIXELS) -> seq_err pulse, go IDLE.
//     - pix_valid low: hold state (gaps allowed, no timeout).
//   READY: pix_valid writes ignored; index-0 write pulses frame_drop. rd_start -> READOUT, frame_ready<=0.
//     rd_start outside READY ignored.
//   READOUT: rd_ptr walks 0..NUM_PIXELS-1; rd_index=rd_ptr, rd_data=store[rd_ptr].
//     - rd_valid rises exactly 2 cycles after the cycle rd_start is sampled.
//     - Beat transfers on rd_valid && rd_ready; next beat valid the following cycle (full throughput).
//     - rd_valid && !rd_ready: rd_data/rd_index/rd_last held stable; rd_valid stays high.
//     - Last beat transfer: rd_valid<=0, frame_done pulses next cycle, state IDLE, rd_ptr<=0.
//     - Index-0 writes during READOUT ignored and pulse frame_drop.
//   Same-cycle write and read legal (different states, no store port conflict).
//   Store: NUM_PIXELS x 1 bit; one write port, one read port with 1-cycle registered read.
//   No combinational path from any input to any output.
// TESTING
//   Write idx 0..783, pixel = idx[0], gaps every 5th cycle; rd_start, rd_ready=1 -> 784 beats, rd_data=idx[0], rd_last at 783, frame_done 1 cycle later.
//   Capture 0..99 then idx 150 -> seq_err 1 cycle, IDLE; rd_start ignored, rd_valid stays 0.
//   Full frame, rd_start, rd_ready toggles 1/0 every cycle -> 784 beats in order, data stable on stall, no beat lost/duplicated.
//   Frame held (frame_ready=1), new idx-0..783 stream -> frame_drop pulse; replay returns original frame.
//   Capture 0..399 then idx 0 -> restart, no seq_err; finish 1..783 -> frame_ready=1.
//   Assert rst at beat 300 of replay -> all outputs 0 immediately; new frame capture and replay then correct.

Source files
------------

// File: rtl/pixel_frame_buffer.sv
// Single-frame 1-bit pixel store: captures a 28x28 binarised frame from the camera
// stream, then replays it in index order to the classifier over valid/ready.
module pixel_frame_buffer #(
   parameter int unsigned WEIGHTS_ADDR = 10,
   parameter int unsigned GRAY_WIDTH   = 8,
   parameter int unsigned NUM_PIXELS   = 784
) (
   input  logic                    pclk,
   input  logic                    rst,
   input  logic                    pix_valid,
   input  logic [GRAY_WIDTH-1:0]   pix_data,
   input  logic [WEIGHTS_ADDR-1:0] pix_index,
   input  logic                    rd_start,
   input  logic                    rd_ready,
   output logic                    frame_ready,
   output logic                    rd_valid,
   output logic [GRAY_WIDTH-1:0]   rd_data,
   output logic [WEIGHTS_ADDR-1:0] rd_index,
   output logic                    rd_last,
   output logic                    frame_done,
   output logic                    seq_err,
   output logic                    frame_drop
);

   // Pointers carry one extra bit so a full 2**WEIGHTS_ADDR frame still has an end marker.
   localparam int unsigned PW = WEIGHTS_ADDR + 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(NUM_PIXELS - 1);
   localparam logic [PW-1:0] END_PTR  = PW'(NUM_PIXELS);

   typedef enum logic [1:0] {IDLE, CAPTURE, READY, READOUT} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   wr_ptr_nxt;
   logic [PW-1:0]   rd_ptr;
   logic            store [NUM_PIXELS];

   logic            wr_en;
   logic            wr_bit;
   logic            idx_zero;
   logic            idx_match;
   logic            load;
   logic            xfer;
   logic            last_xfer;
   logic            rd_begin;
   logic            seq_err_nxt;
   logic            frame_drop_nxt;
   logic            frame_ready_nxt;

   assign wr_bit    = |pix_data;
   assign idx_zero  = (pix_index == '0);
   assign idx_match = ({1'b0, pix_index} == wr_ptr);
   assign xfer      = rd_valid && rd_ready;
   assign last_xfer = xfer && rd_last;
   // Fetch the next pixel whenever the output register is empty or being drained.
   assign load      = (state == READOUT) && (rd_ptr != END_PTR) && (!rd_valid || rd_ready);

   // State register.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and write/handshake control.
   always_comb begin
      state_nxt       = state;
      wr_en           = 1'b0;
      wr_ptr_nxt      = wr_ptr;
      seq_err_nxt     = 1'b0;
      frame_drop_nxt  = 1'b0;
      frame_ready_nxt = frame_ready;
      rd_begin        = 1'b0;
      case (state)
         IDLE: begin
            if (pix_valid && idx_zero) begin
               wr_en      = 1'b1;
               wr_ptr_nxt = PW'(1);
               state_nxt  = CAPTURE;
            end
         end
         CAPTURE: begin
            if (pix_valid) begin
               if (idx_match) begin
                  wr_en = 1'b1;
                  if (wr_ptr == LAST_PTR) begin
                     wr_ptr_nxt      = '0;
                     frame_ready_nxt = 1'b1;
                     state_nxt       = READY;
                  end else begin
                     wr_ptr_nxt = wr_ptr + PW'(1);
                  end
               end else if (idx_zero) begin
                  // Camera restarted the frame: begin again silently.
                  wr_en      = 1'b1;
                  wr_ptr_nxt = PW'(1);
               end else begin
                  seq_err_nxt = 1'b1;
                  wr_ptr_nxt  = '0;
                  state_nxt   = IDLE;
               end
            end
         end
         READY: begin
            frame_drop_nxt = pix_valid && idx_zero;
            if (rd_start) begin
               rd_begin        = 1'b1;
               frame_ready_nxt = 1'b0;
               state_nxt       = READOUT;
            end
         end
         READOUT: begin
            frame_drop_nxt = pix_valid && idx_zero;
            if (last_xfer) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Pixel store write port; only in-range indices ever reach it.
   always_ff @(posedge pclk) begin
      if (wr_en) begin
         store[pix_index] <= wr_bit;
      end
   end

   // Pointers, status pulses and the registered read beat.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         frame_ready <= 1'b0;
         seq_err     <= 1'b0;
         frame_drop  <= 1'b0;
         frame_done  <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         rd_index    <= '0;
         rd_last     <= 1'b0;
      end else begin
         wr_ptr      <= wr_ptr_nxt;
         frame_ready <= frame_ready_nxt;
         seq_err     <= seq_err_nxt;
         frame_drop  <= frame_drop_nxt;
         frame_done  <= last_xfer;

         if (rd_begin || last_xfer) begin
            rd_ptr <= '0;
         end else if (load) begin
            rd_ptr <= rd_ptr + PW'(1);
         end

         if (load) begin
            rd_valid <= 1'b1;
            rd_data  <= {{(GRAY_WIDTH-1){1'b0}}, store[rd_ptr[WEIGHTS_ADDR-1:0]]};
            rd_index <= rd_ptr[WEIGHTS_ADDR-1:0];
            rd_last  <= (rd_ptr == LAST_PTR);
         end else if (xfer) begin
            rd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Scoreboard bench for pixel_frame_buffer: directed capture/replay scenarios.
module tb_pixel_frame_buffer;

   localparam int N = 784;

   logic       pclk;
   logic       rst;
   logic       pix_valid;
   logic [7:0] pix_data;
   logic [9:0] pix_index;
   logic       rd_start;
   logic       rd_ready;
   logic       frame_ready;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic [9:0] rd_index;
   logic       rd_last;
   logic       frame_done;
   logic       seq_err;
   logic       frame_drop;

   pixel_frame_buffer dut (
      .pclk(pclk), .rst(rst),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_index(pix_index),
      .rd_start(rd_start), .rd_ready(rd_ready),
      .frame_ready(frame_ready), .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_index(rd_index), .rd_last(rd_last), .frame_done(frame_done),
      .seq_err(seq_err), .frame_drop(frame_drop)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   typedef struct {
      logic [7:0] d;
      logic [9:0] i;
      logic       l;
   } beat_t;

   beat_t sb[$];
   beat_t held;
   beat_t exp_b;
   int    errors = 0;
   int    checks = 0;
   int    xfers  = 0;
   int    n_seq  = 0;
   int    n_drop = 0;
   int    n_done = 0;
   logic  stall_prev = 1'b0;
   logic  last_prev  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expected stored bit for pattern p at index i.
   function automatic logic pat(input int p, input int i);
      case (p)
         0:       return i[0];
         1:       return i[1];
         2:       return (i % 3) == 0;
         3:       return 1'b1;
         default: return i[2] ^ i[5];
      endcase
   endfunction

   // Monitor: compares every transferred beat with the scoreboard, checks stall stability and frame_done timing.
   always @(negedge pclk) begin
      if (rst) begin
         stall_prev = 1'b0;
         last_prev  = 1'b0;
      end else begin
         if (seq_err)    n_seq++;
         if (frame_drop) n_drop++;
         if (frame_done) n_done++;
         if (frame_done || last_prev) chk("frame_done_timing", 32'(frame_done), 32'(last_prev));
         if (stall_prev) begin
            chk("stall_valid", 32'(rd_valid), 32'd1);
            chk("stall_data",  32'(rd_data),  32'(held.d));
            chk("stall_index", 32'(rd_index), 32'(held.i));
            chk("stall_last",  32'(rd_last),  32'(held.l));
         end
         stall_prev = 1'b0;
         last_prev  = 1'b0;
         if (rd_valid && rd_ready) begin
            xfers++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: index %0d arrived, none expected", rd_index);
            end else begin
               exp_b = sb.pop_front();
               chk("beat_data",  32'(rd_data),  32'(exp_b.d));
               chk("beat_index", 32'(rd_index), 32'(exp_b.i));
               chk("beat_last",  32'(rd_last),  32'(exp_b.l));
            end
            last_prev = rd_last;
         end else if (rd_valid) begin
            stall_prev = 1'b1;
            held.d = rd_data;
            held.i = rd_index;
            held.l = rd_last;
         end
      end
   end

   task automatic cyc();
      @(posedge pclk);
      #1;
   endtask

   task automatic send(input int idx, input logic [7:0] d);
      pix_valid = 1'b1;
      pix_index = 10'(idx);
      pix_data  = d;
      cyc();
      pix_valid = 1'b0;
   endtask

   // Writes indices lo..hi of pattern p; nonzero pixels use varied byte values.
   task automatic write_range(input int p, input int lo, input int hi, input bit gaps);
      for (int i = lo; i <= hi; i++) begin
         if (gaps && (i % 5 == 4)) cyc();
         send(i, pat(p, i) ? ((i % 7 == 0) ? 8'h80 : 8'h01) : 8'h00);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_frame_ready"}, 32'(frame_ready), 0);
      chk({tag, "_rd_valid"},    32'(rd_valid),    0);
      chk({tag, "_rd_data"},     32'(rd_data),     0);
      chk({tag, "_rd_index"},    32'(rd_index),    0);
      chk({tag, "_rd_last"},     32'(rd_last),     0);
      chk({tag, "_frame_done"},  32'(frame_done),  0);
      chk({tag, "_seq_err"},     32'(seq_err),     0);
      chk({tag, "_frame_drop"},  32'(frame_drop),  0);
   endtask

   // Replays the held frame expecting pattern p; mode 1 toggles rd_ready; abort_at>=0 resets after that many beats.
   task automatic replay(input int p, input int mode, input int abort_at);
      int    x0;
      int    d0;
      int    n;
      beat_t b;
      bit    aborted;
      aborted = 1'b0;
      for (int i = 0; i < N; i++) begin
         b.d = pat(p, i) ? 8'd1 : 8'd0;
         b.i = 10'(i);
         b.l = (i == N - 1);
         sb.push_back(b);
      end
      d0 = n_done;
      x0 = xfers;
      rd_ready = 1'b1;
      rd_start = 1'b1;
      cyc();
      rd_start = 1'b0;
      chk("frame_ready_cleared", 32'(frame_ready), 0);
      chk("rd_valid_latency1",   32'(rd_valid),    0);
      cyc();
      chk("rd_valid_latency2",   32'(rd_valid),    1);
      n = 0;
      while (sb.size() != 0 && n < 4000) begin
         if (abort_at >= 0 && (xfers - x0) >= abort_at) begin
            rst = 1'b1;
            #1;
            check_outputs_zero("reset_mid_replay");
            sb.delete();
            cyc();
            rst = 1'b0;
            aborted = 1'b1;
            break;
         end
         if (mode == 1) rd_ready = ~rd_ready;
         cyc();
         n++;
      end
      if (!aborted) begin
         if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL replay_timeout: %0d beats outstanding", sb.size());
            sb.delete();
         end
         chk("rd_valid_after_last", 32'(rd_valid), 0);
         cyc();
         cyc();
         chk("frame_done_count", 32'(n_done - d0), 1);
      end
      rd_ready = 1'b0;
   endtask

   initial begin
      int s0;
      int bad;
      rst       = 1'b1;
      pix_valid = 1'b0;
      pix_data  = '0;
      pix_index = '0;
      rd_start  = 1'b0;
      rd_ready  = 1'b0;
      repeat (3) cyc();
      check_outputs_zero("reset");
      rst = 1'b0;
      cyc();

      // Full frame with gaps, full-throughput replay.
      write_range(0, 0, N - 1, 1'b1);
      chk("s1_frame_ready", 32'(frame_ready), 1);
      replay(0, 0, -1);

      // Sequence error mid-capture aborts to IDLE; rd_start then ignored.
      s0 = n_seq;
      write_range(3, 0, 99, 1'b0);
      send(150, 8'h01);
      chk("s2_seq_err_pulse", 32'(seq_err), 1);
      chk("s2_frame_ready",   32'(frame_ready), 0);
      cyc();
      chk("s2_seq_err_width", 32'(seq_err), 0);
      chk("s2_seq_err_count", 32'(n_seq - s0), 1);
      rd_start = 1'b1;
      rd_ready = 1'b1;
      cyc();
      rd_start = 1'b0;
      bad = 0;
      repeat (4) begin
         cyc();
         if (rd_valid) bad++;
      end
      chk("s2_no_replay", 32'(bad), 0);
      rd_ready = 1'b0;

      // Replay under rd_ready toggling every cycle.
      write_range(4, 0, N - 1, 1'b1);
      replay(4, 1, -1);

      // New stream while a frame is held: one drop pulse, original frame kept.
      write_range(2, 0, N - 1, 1'b0);
      s0 = n_drop;
      write_range(1, 0, N - 1, 1'b1);
      cyc();
      chk("s4_frame_ready", 32'(frame_ready), 1);
      chk("s4_drop_count",  32'(n_drop - s0), 1);
      replay(2, 0, -1);

      // Restart at index 0 mid-capture without error.
      s0 = n_seq;
      write_range(3, 0, 399, 1'b0);
      write_range(1, 0, N - 1, 1'b0);
      chk("s5_frame_ready",   32'(frame_ready), 1);
      chk("s5_no_seq_err",    32'(n_seq - s0), 0);
      replay(1, 0, -1);

      // Reset during replay, then a fresh frame must capture and replay correctly.
      write_range(0, 0, N - 1, 1'b0);
      replay(0, 0, 300);
      cyc();
      check_outputs_zero("after_reset");
      write_range(2, 0, N - 1, 1'b1);
      chk("s6_frame_ready", 32'(frame_ready), 1);
      replay(2, 1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
